row_fifo_arbiter: RTL and testbench
===================================

ROW_FIFO_ARBITER -- requirements
Module: row_fifo_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 32, bits per word.
- ROW_SIZE, 3, words per row.
- NUM_REQ, 4, number of requesters (>=2).
- BURST_MAX, 4, maximum rows per grant (>=1).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester row valid.
- req_last  in  NUM_REQ  per-requester last row of burst.
- req_data  in  NUM_REQ x ROW_SIZE x WIDTH  per-requester row.
- req_ready  out  NUM_REQ  per-requester row accepted.
- fifo_full  in  1  downstream row FIFO full.
- fifo_we  out  1  downstream FIFO write enable.
- fifo_data  out  ROW_SIZE x WIDTH  downstream FIFO row.
- grant_valid  out  1  a burst grant is active.
- grant_id  out  max(1,$clog2(NUM_REQ))  index of granted requester.

Function
REQ-003 The block SHALL implement FSM states IDLE and BURST, plus a registered round-robin pointer rr_ptr, grant_id register and beat counter (width $clog2(BURST_MAX+1)).
REQ-004 In IDLE, if any req_valid is 1, the block SHALL select the first requester i with req_valid[i]=1 scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ, load grant_id=i, clear beat counter, and enter BURST on the next edge.
REQ-005 In IDLE, req_ready SHALL be all-zero, fifo_we 0, grant_valid 0; grant latency from req_valid to grant_valid SHALL be exactly 1 cycle.
REQ-006 In BURST, grant_valid SHALL be 1, req_ready[grant_id] SHALL equal !fifo_full, all other req_ready bits SHALL be 0.
REQ-007 A transfer SHALL occur in a BURST cycle where req_valid[grant_id] and req_ready[grant_id] are both 1; fifo_we SHALL be 1 combinationally in exactly those cycles.
REQ-008 fifo_data SHALL equal req_data[grant_id] whenever grant_valid=1 and all-zero otherwise.
REQ-009 Each transfer SHALL increment the beat counter by 1.
REQ-010 BURST SHALL end (return to IDLE next edge) on: a transfer with req_last[grant_id]=1; a transfer bringing beat count to BURST_MAX; or req_valid[grant_id]=0 while fifo_full=0.
REQ-011 On burst end the block SHALL set rr_ptr = (grant_id+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-012 While fifo_full=1 in BURST the block SHALL hold grant, beat counter and FSM state indefinitely; fifo_we SHALL never be 1 while fifo_full=1.
REQ-013 Changes on non-granted req_valid/req_data during BURST SHALL have no effect on outputs.
REQ-014 At most one fifo_we per cycle; no row SHALL be dropped or duplicated; after each burst end, IDLE SHALL last exactly 1 cycle before the next grant if any request is pending.

Reset
REQ-015 On reset_n=0, asynchronously: FSM=IDLE, rr_ptr=0, grant_id=0, beat counter=0; hence req_ready=0, fifo_we=0, grant_valid=0, fifo_data=0.
REQ-016 Reset asserted mid-burst SHALL abort the burst with no further fifo_we; after release, arbitration SHALL restart from rr_ptr=0.

Verification
REQ-017 Bench SHALL cover (NUM_REQ=4, BURST_MAX=4, ROW_SIZE=3, WIDTH=32):
- All four req_valid=1 continuously, req_last=0 -> grants 0,1,2,3,0 in order, each 4 fifo_we pulses, 1 IDLE cycle between grants.
- Only requester 2 valid, 2 rows, req_last on row 2 -> grant_valid 1 cycle after req_valid, fifo_data matches both rows, rr_ptr=3 after.
- fifo_full=1 for 5 cycles mid-burst -> req_ready[grant_id]=0, fifo_we=0, grant_id and beat count unchanged; burst completes after release.
- Granted requester drops req_valid after 1 row, fifo_full=0 -> burst ends, next requester granted.
- reset_n pulsed low mid-burst -> all outputs 0 immediately; first grant after reset goes to lowest valid index.
- Requester 3 granted, ends burst -> rr_ptr wraps to 0.

Source files
------------

// File: rtl/row_fifo_arbiter.sv
// Round-robin arbiter that grants one requester at a time a burst of whole rows
// into a shared downstream row FIFO.
module row_fifo_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ROW_SIZE  = 3,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                                           clock,
    input  logic                                           reset_n,
    input  logic [NUM_REQ-1:0]                             req_valid,
    input  logic [NUM_REQ-1:0]                             req_last,
    input  logic [NUM_REQ-1:0][ROW_SIZE-1:0][WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]                             req_ready,
    input  logic                                           fifo_full,
    output logic                                           fifo_we,
    output logic [ROW_SIZE-1:0][WIDTH-1:0]                 fifo_data,
    output logic                                           grant_valid,
    output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] grant_id
);

    localparam int IdW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BeatW = $clog2(BURST_MAX + 1);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]   grant_id_q, grant_id_d;
    logic [BeatW-1:0] beat_q, beat_d;

    logic             pick_found;
    logic [IdW-1:0]   pick_id;
    logic [IdW-1:0]   scan_idx;
    logic             xfer;
    logic             beat_hit;
    logic             burst_end;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_q     <= beat_d;
        end
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            scan_idx = IdW'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
            if (!pick_found && req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

    assign xfer     = (state_q == StBurst) && req_valid[grant_id_q] && !fifo_full;
    assign beat_hit = (beat_q + BeatW'(1)) == BeatW'(BURST_MAX);
    // A stalled FIFO never ends a burst; an idle granted requester only does when unstalled.
    assign burst_end = (xfer && (req_last[grant_id_q] || beat_hit)) ||
                       (!req_valid[grant_id_q] && !fifo_full);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_d     = beat_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d    = StBurst;
                    grant_id_d = pick_id;
                    beat_d     = '0;
                end
            end
            StBurst: begin
                if (xfer) begin
                    beat_d = beat_q + BeatW'(1);
                end
                if (burst_end) begin
                    state_d  = StIdle;
                    rr_ptr_d = (grant_id_q == IdW'(NUM_REQ - 1)) ? '0 : grant_id_q + IdW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        grant_valid = (state_q == StBurst);
        grant_id    = grant_id_q;
        req_ready   = '0;
        fifo_data   = '0;
        fifo_we     = xfer;
        if (grant_valid) begin
            req_ready[grant_id_q] = !fifo_full;
            fifo_data             = req_data[grant_id_q];
        end
    end

endmodule

// File: tb/tb_row_fifo_arbiter.sv
// Directed bench for row_fifo_arbiter: round-robin order, burst limits, FIFO stall,
// early drop of a granted requester and asynchronous reset mid-burst.
module tb_row_fifo_arbiter;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic [3:0]            req_valid;
    logic [3:0]            req_last;
    logic [3:0][2:0][31:0] req_data;
    logic [3:0]            req_ready;
    logic                  fifo_full;
    logic                  fifo_we;
    logic [2:0][31:0]      fifo_data;
    logic                  grant_valid;
    logic [1:0]            grant_id;

    int checks = 0;
    int errors = 0;

    row_fifo_arbiter #(
        .WIDTH    (32),
        .ROW_SIZE (3),
        .NUM_REQ  (4),
        .BURST_MAX(4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_we    (fifo_we),
        .fifo_data  (fifo_data),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always #5 clock = ~clock;

    function automatic logic [95:0] row_val(input int r, input int n);
        return {8'(r), 24'(n), 32'(r * 7 + n + 1), ~32'(n)};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_idle(input string tag);
        #1;
        chk({tag, ":grant_valid"}, 96'(grant_valid), 96'(0));
        chk({tag, ":req_ready"}, 96'(req_ready), 96'(0));
        chk({tag, ":fifo_we"}, 96'(fifo_we), 96'(0));
        chk({tag, ":fifo_data"}, 96'(fifo_data), 96'(0));
    endtask

    task automatic exp_burst(input string tag, input int gid, input logic we,
                             input logic [3:0] rdy, input logic [95:0] data);
        #1;
        chk({tag, ":grant_valid"}, 96'(grant_valid), 96'(1));
        chk({tag, ":grant_id"}, 96'(grant_id), 96'(gid));
        chk({tag, ":req_ready"}, 96'(req_ready), 96'(rdy));
        chk({tag, ":fifo_we"}, 96'(fifo_we), 96'(we));
        chk({tag, ":fifo_data"}, 96'(fifo_data), data);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) req_data[i] = row_val(i, 0);
        #3;
        exp_idle("reset");
        step();
        reset_n = 1'b1;

        // All requesters busy, no last: 0,1,2,3,0 with 4 beats each and one idle cycle between.
        req_valid = 4'hF;
        for (int b = 0; b < 5; b++) begin
            exp_idle($sformatf("rr_idle%0d", b));
            step();
            for (int k = 0; k < 4; k++) begin
                exp_burst($sformatf("rr_g%0d_b%0d", b, k), b % 4, 1'b1, 4'(1 << (b % 4)),
                          row_val(b % 4, 0));
                step();
            end
        end
        req_valid = '0;
        exp_idle("rr_end");
        step();
        exp_idle("quiet");

        // Lone requester 2, two rows, last on the second; rr_ptr currently 1.
        req_valid = 4'b0100;
        exp_idle("r2_idle");
        step();
        exp_burst("r2_row0", 2, 1'b1, 4'b0100, row_val(2, 0));
        step();
        req_data[2] = row_val(2, 1);
        req_last[2] = 1'b1;
        exp_burst("r2_row1", 2, 1'b1, 4'b0100, row_val(2, 1));
        step();
        req_valid   = '0;
        req_last    = '0;
        req_data[2] = row_val(2, 0);
        exp_idle("r2_done");
        step();

        // rr_ptr is now 3: requester 3 wins, single-row burst, then the pointer wraps to 0.
        req_valid = 4'hF;
        exp_idle("wrap_idle");
        step();
        req_last[3] = 1'b1;
        exp_burst("wrap_g3", 3, 1'b1, 4'b1000, row_val(3, 0));
        step();
        req_last = '0;
        exp_idle("wrap_idle2");
        step();

        // FIFO full for 5 cycles after the first beat; beat count must hold.
        exp_burst("stall_b0", 0, 1'b1, 4'b0001, row_val(0, 0));
        step();
        fifo_full   = 1'b1;
        req_data[1] = 96'hDEAD_BEEF_0BAD_F00D_1234_5678;
        for (int s = 0; s < 5; s++) begin
            exp_burst($sformatf("stall_s%0d", s), 0, 1'b0, 4'b0000, row_val(0, 0));
            step();
        end
        fifo_full   = 1'b0;
        req_data[1] = row_val(1, 0);
        for (int k = 1; k < 4; k++) begin
            exp_burst($sformatf("stall_rel_b%0d", k), 0, 1'b1, 4'b0001, row_val(0, 0));
            step();
        end
        exp_idle("stall_done");
        step();

        // Granted requester 1 drops valid after one row.
        exp_burst("drop_b0", 1, 1'b1, 4'b0010, row_val(1, 0));
        step();
        req_valid[1] = 1'b0;
        exp_burst("drop_gap", 1, 1'b0, 4'b0010, row_val(1, 0));
        step();
        exp_idle("drop_idle");
        step();

        // Reset mid-burst of requester 2; afterwards scanning restarts at 0.
        exp_burst("rst_pre", 2, 1'b1, 4'b0100, row_val(2, 0));
        reset_n = 1'b0;
        exp_idle("rst_async");
        step();
        exp_idle("rst_hold");
        reset_n   = 1'b1;
        req_valid = 4'b0110;
        exp_idle("rst_rel");
        step();
        exp_burst("rst_first", 1, 1'b1, 4'b0010, row_val(1, 0));
        req_valid = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
